// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding and the PC-source codes driven by the control unit.
// Pure declarations, no logic.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HOLD = 2'b10,
    ST_ERR  = 2'b11
  } fetch_state_t;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_J   = 2'b10;
  localparam logic [1:0] PCSEL_JR  = 2'b11;

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection and pc+4 link value; zero latency.
// No state, no flow control; all sums wrap mod 2^32.
module mips_next_pc
  import mips_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  sm5,
  input  logic [31:0] branchOffset,
  input  logic [25:0] jumpTarget,
  input  logic [31:0] jrTarget,
  output logic [31:0] pcPlus4,
  output logic [31:0] nextPc
);

  assign pcPlus4 = pc + 32'd4;

  always_comb begin
    nextPc = pcPlus4;
    case (sm5)
      PCSEL_SEQ: nextPc = pcPlus4;
      PCSEL_BR:  nextPc = pcPlus4 + (branchOffset << 2);
      PCSEL_J:   nextPc = {pcPlus4[31:28], jumpTarget, 2'b00};
      PCSEL_JR:  nextPc = jrTarget;
      default:   nextPc = pcPlus4;
    endcase
  end

endmodule

// File: rtl/mips_fetch.sv
// Fetch/PC stage: req/ack fetch from variable-latency imem, holds the word until commit; min 2 cycles/inst.
// Memory stalls by withholding ack (address held stable); datapath stalls by withholding commit.
module mips_fetch
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sm5,
  input  logic [31:0] branchOffset,
  input  logic [25:0] jumpTarget,
  input  logic [31:0] jrTarget,
  input  logic        commit,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] inst,
  output logic        instValid,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        addrErr,
  output logic [31:0] instCount
);

  fetch_state_t state;
  logic [31:0]  next_pc;
  logic         jr_misaligned;

  mips_next_pc u_next_pc (
    .pc           (pc),
    .sm5          (sm5),
    .branchOffset (branchOffset),
    .jumpTarget   (jumpTarget),
    .jrTarget     (jrTarget),
    .pcPlus4      (pcPlus4),
    .nextPc       (next_pc)
  );

  assign jr_misaligned = (sm5 == PCSEL_JR) && (jrTarget[1:0] != 2'b00);

  // Pure state decode so memory never sees a combinational path from its own ack.
  assign imemReq  = (state == ST_REQ);
  assign imemAddr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      inst      <= 32'h0;
      instValid <= 1'b0;
      addrErr   <= 1'b0;
      instCount <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ: begin
          if (imemAck) begin
            inst      <= imemData;
            instValid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (commit) begin
            instValid <= 1'b0;
            instCount <= instCount + 32'd1;
            // A misaligned jr still retires the jr itself, but the PC is frozen for debug.
            if (jr_misaligned) begin
              addrErr <= 1'b1;
              state   <= ST_ERR;
            end else begin
              pc    <= next_pc;
              state <= ST_REQ;
            end
          end
        end
        ST_ERR:  state <= ST_ERR;
        default: state <= ST_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch.sv
// Directed self-checking bench for mips_fetch: sequential, branch, jump, jr, error, latency and reset cases.
module tb_mips_fetch;
  import mips_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sm5;
  logic [31:0] branchOffset;
  logic [25:0] jumpTarget;
  logic [31:0] jrTarget;
  logic        commit;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] inst;
  logic        instValid;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        addrErr;
  logic [31:0] instCount;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .sm5          (sm5),
    .branchOffset (branchOffset),
    .jumpTarget   (jumpTarget),
    .jrTarget     (jrTarget),
    .commit       (commit),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemAck      (imemAck),
    .imemData     (imemData),
    .inst         (inst),
    .instValid    (instValid),
    .pc           (pc),
    .pcPlus4      (pcPlus4),
    .addrErr      (addrErr),
    .instCount    (instCount)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory answers lat cycles after the request became visible.
  task automatic fetch(input logic [31:0] data, input int lat);
    for (int i = 0; i < lat; i++) begin
      imemAck = 1'b0;
      tick();
    end
    imemAck  = 1'b1;
    imemData = data;
    tick();
    imemAck  = 1'b0;
  endtask

  task automatic commit_inst(input logic [1:0] sel, input logic [31:0] bo,
                             input logic [25:0] jt, input logic [31:0] jr);
    sm5          = sel;
    branchOffset = bo;
    jumpTarget   = jt;
    jrTarget     = jr;
    commit       = 1'b1;
    tick();
    commit       = 1'b0;
    sm5          = 2'b00;
    branchOffset = 32'h0;
    jumpTarget   = 26'h0;
    jrTarget     = 32'h0;
  endtask

  task automatic test_reset;
    rst = 1'b1; sm5 = 2'b00; branchOffset = 32'h0; jumpTarget = 26'h0; jrTarget = 32'h0;
    commit = 1'b0; imemAck = 1'b0; imemData = 32'h0;
    tick(); tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want %h", inst, 32'h0); end
    checks++; if (instValid !== 1'b0) begin errors++; $display("FAIL reset_instValid: got %b want 0", instValid); end
    checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL reset_imemReq: got %b want 0", imemReq); end
    checks++; if (addrErr !== 1'b0) begin errors++; $display("FAIL reset_addrErr: got %b want 0", addrErr); end
    checks++; if (instCount !== 32'h0) begin errors++; $display("FAIL reset_instCount: got %0d want 0", instCount); end
    rst = 1'b0;
    tick();
    checks++; if (imemReq !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imemReq); end
  endtask

  task automatic test_sequential;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (imemAddr !== 32'(4 * k)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", k, imemAddr, 32'(4 * k)); end
      fetch(32'h2000_0000 | 32'(k), 0);
      checks++;
      if (instValid !== 1'b1 || inst !== (32'h2000_0000 | 32'(k)))
        begin errors++; $display("FAIL seq_inst%0d: got v=%b %h want v=1 %h", k, instValid, inst, 32'h2000_0000 | 32'(k)); end
      commit_inst(PCSEL_SEQ, 32'h0, 26'h0, 32'h0);
    end
    checks++; if (instCount !== 32'd4) begin errors++; $display("FAIL seq_count: got %0d want 4", instCount); end
    checks++; if (imemAddr !== 32'h10) begin errors++; $display("FAIL seq_final_addr: got %h want 00000010", imemAddr); end
  endtask

  task automatic test_branch;
    fetch(32'h0, 0); commit_inst(PCSEL_JR, 32'h0, 26'h0, 32'h0000_0100);
    checks++; if (imemAddr !== 32'h100) begin errors++; $display("FAIL jr_aligned: got %h want 00000100", imemAddr); end
    fetch(32'h1000_FFFE, 0); commit_inst(PCSEL_BR, 32'hFFFF_FFFE, 26'h0, 32'h0);
    checks++; if (pc !== 32'h0FC) begin errors++; $display("FAIL branch_back: got %h want 000000fc", pc); end
    fetch(32'h0, 0); commit_inst(PCSEL_JR, 32'h0, 26'h0, 32'h0000_0100);
    fetch(32'h1000_0003, 0); commit_inst(PCSEL_BR, 32'h0000_0003, 26'h0, 32'h0);
    checks++; if (pc !== 32'h110) begin errors++; $display("FAIL branch_fwd: got %h want 00000110", pc); end
  endtask

  task automatic test_jump;
    fetch(32'h0, 0); commit_inst(PCSEL_JR, 32'h0, 26'h0, 32'hF000_0010);
    checks++; if (pcPlus4 !== 32'hF000_0014) begin errors++; $display("FAIL pcplus4: got %h want f0000014", pcPlus4); end
    fetch(32'h0800_0040, 0); commit_inst(PCSEL_J, 32'h0, 26'h000_0040, 32'h0);
    checks++; if (imemAddr !== 32'hF000_0100) begin errors++; $display("FAIL jump: got %h want f0000100", imemAddr); end
    fetch(32'h0, 0); commit_inst(PCSEL_JR, 32'h0, 26'h0, 32'hFFFF_FFFC);
    checks++; if (pcPlus4 !== 32'h0) begin errors++; $display("FAIL pcplus4_wrap: got %h want 00000000", pcPlus4); end
    fetch(32'h0, 0); commit_inst(PCSEL_SEQ, 32'h0, 26'h0, 32'h0);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h want 00000000", pc); end
    checks++; if (instCount !== 32'd12) begin errors++; $display("FAIL jump_count: got %0d want 12", instCount); end
  endtask

  task automatic test_jr_error;
    fetch(32'h0, 0); commit_inst(PCSEL_JR, 32'h0, 26'h0, 32'hF000_0100);
    fetch(32'h0, 0); commit_inst(PCSEL_JR, 32'h0, 26'h0, 32'h0000_0202);
    checks++; if (addrErr !== 1'b1) begin errors++; $display("FAIL err_flag: got %b want 1", addrErr); end
    checks++; if (pc !== 32'hF000_0100) begin errors++; $display("FAIL err_pc: got %h want f0000100", pc); end
    checks++; if (instValid !== 1'b0) begin errors++; $display("FAIL err_valid: got %b want 0", instValid); end
    checks++; if (instCount !== 32'd14) begin errors++; $display("FAIL err_count: got %0d want 14", instCount); end
    commit = 1'b1; imemAck = 1'b1; imemData = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (imemReq !== 1'b0 || pc !== 32'hF000_0100 || addrErr !== 1'b1 || inst === 32'hBAD0_BAD0)
        begin errors++; $display("FAIL err_stuck%0d: req=%b pc=%h err=%b inst=%h want req=0 pc=f0000100 err=1", i, imemReq, pc, addrErr, inst); end
    end
    commit = 1'b0; imemAck = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (addrErr !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", addrErr); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (imemReq !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL err_restart: req=%b pc=%h want req=1 pc=0", imemReq, pc); end
  endtask

  task automatic test_latency3;
    commit = 1'b1; sm5 = PCSEL_JR; jrTarget = 32'h40;
    tick();
    commit = 1'b0; sm5 = 2'b00; jrTarget = 32'h0;
    checks++; if (imemAddr !== 32'h0 || instCount !== 32'h0) begin errors++; $display("FAIL req_commit_ignored: addr=%h cnt=%0d want 0 0", imemAddr, instCount); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (imemReq !== 1'b1 || imemAddr !== 32'h0 || instValid !== 1'b0)
        begin errors++; $display("FAIL wait%0d: req=%b addr=%h v=%b want 1 0 0", i, imemReq, imemAddr, instValid); end
    end
    fetch(32'hDEAD_BEEF, 0);
    checks++; if (instValid !== 1'b1 || inst !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lat3_inst: v=%b %h want 1 deadbeef", instValid, inst); end
    imemAck = 1'b1; imemData = 32'h1234_5678;
    tick();
    imemAck = 1'b0;
    checks++;
    if (inst !== 32'hDEAD_BEEF || instValid !== 1'b1 || imemReq !== 1'b0)
      begin errors++; $display("FAIL spurious_ack: inst=%h v=%b req=%b want deadbeef 1 0", inst, instValid, imemReq); end
    commit_inst(PCSEL_SEQ, 32'h0, 26'h0, 32'h0);
    checks++;
    if (inst !== 32'hDEAD_BEEF || instValid !== 1'b0 || pc !== 32'h4 || instCount !== 32'd1)
      begin errors++; $display("FAIL stale_inst: inst=%h v=%b pc=%h cnt=%0d want deadbeef 0 4 1", inst, instValid, pc, instCount); end
  endtask

  task automatic test_reset_in_hold;
    fetch(32'hCAFE_F00D, 1);
    checks++; if (instValid !== 1'b1) begin errors++; $display("FAIL hold_before_rst: got %b want 1", instValid); end
    rst = 1'b1;
    #1;
    checks++;
    if (instValid !== 1'b0 || pc !== 32'h0 || instCount !== 32'h0 || inst !== 32'h0)
      begin errors++; $display("FAIL async_rst: v=%b pc=%h cnt=%0d inst=%h want 0 0 0 0", instValid, pc, instCount, inst); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (imemReq !== 1'b1) begin errors++; $display("FAIL rst_restart: got %b want 1", imemReq); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_jr_error();
    test_latency3();
    test_reset_in_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
